// File: rtl/uart_rx_if.sv
// Parallel output bundle of the UART receiver: recovered word, completion pulse, error flags, busy.
// The receiver drives it through the master modport; the host-side consumer reads it through slave.
interface uart_rx_if;
  logic [8:0] rx_dat;
  logic       rx_vld;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (output rx_dat, output rx_vld, output parity_err, output frame_err, output busy);
  modport slave  (input  rx_dat, input  rx_vld, input  parity_err, input  frame_err, input  busy);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop recovery onto a parallel word; rx_vld rises one
// clock after the tick sampling the last stop bit. No backpressure: the consumer must take each pulse.
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_config,
  input  logic       i_sample_tick,
  input  logic       i_rx,
  uart_rx_if.master  rx_bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic [8:0]             shift_q, shift_d;
  logic                   par_acc_q, par_acc_d;
  logic                   perr_f_q, perr_f_d;
  logic                   ferr_f_q, ferr_f_d;
  logic                   stop2nd_q, stop2nd_d;
  logic                   armed_q, armed_d;
  logic                   cfg_stop2_q, cfg_stop2_d;
  logic                   cfg_par_q, cfg_par_d;
  logic [3:0]             cfg_wsize_q, cfg_wsize_d;
  logic [8:0]             dat_q, dat_d;
  logic                   vld_q, vld_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic [3:0]             wsize_req;
  logic                   stop_err;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign wsize_req = i_config[4:1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q      <= '1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      par_acc_q   <= 1'b0;
      perr_f_q    <= 1'b0;
      ferr_f_q    <= 1'b0;
      stop2nd_q   <= 1'b0;
      armed_q     <= 1'b1;
      cfg_stop2_q <= 1'b0;
      cfg_par_q   <= 1'b1;
      cfg_wsize_q <= 4'd8;
      dat_q       <= '0;
      vld_q       <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], i_rx};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      par_acc_q   <= par_acc_d;
      perr_f_q    <= perr_f_d;
      ferr_f_q    <= ferr_f_d;
      stop2nd_q   <= stop2nd_d;
      armed_q     <= armed_d;
      cfg_stop2_q <= cfg_stop2_d;
      cfg_par_q   <= cfg_par_d;
      cfg_wsize_q <= cfg_wsize_d;
      dat_q       <= dat_d;
      vld_q       <= vld_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    par_acc_d   = par_acc_q;
    perr_f_d    = perr_f_q;
    ferr_f_d    = ferr_f_q;
    stop2nd_d   = stop2nd_q;
    armed_d     = armed_q;
    cfg_stop2_d = cfg_stop2_q;
    cfg_par_d   = cfg_par_q;
    cfg_wsize_d = cfg_wsize_q;
    dat_d       = dat_q;
    vld_d       = 1'b0;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    stop_err    = ferr_f_q | ~rx_s;

    if (state_q == IDLE && i_config[0]) begin
      cfg_stop2_d = i_config[6];
      cfg_par_d   = i_config[5];
      if (wsize_req < 4'd5)      cfg_wsize_d = 4'd5;
      else if (wsize_req > 4'd9) cfg_wsize_d = 4'd9;
      else                       cfg_wsize_d = wsize_req;
    end

    if (i_sample_tick) begin
      case (state_q)
        IDLE: begin
          // armed only re-arms on a high sample, so a held break cannot start frames
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == HALF) begin
            if (!rx_s) begin
              state_d   = DATA;
              cnt_d     = '0;
              bit_idx_d = '0;
              shift_d   = '0;
              par_acc_d = 1'b0;
              perr_f_d  = 1'b0;
              ferr_f_d  = 1'b0;
              stop2nd_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            shift_d[bit_idx_q] = rx_s;
            par_acc_d = par_acc_q ^ rx_s;
            if (bit_idx_q == cfg_wsize_q - 4'd1) state_d = cfg_par_q ? PARITY : STOP;
            else                                 bit_idx_d = bit_idx_q + 4'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (cnt_q == LAST) begin
            cnt_d    = '0;
            perr_f_d = rx_s ^ par_acc_q;
            state_d  = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (cfg_stop2_q && !stop2nd_q) begin
              stop2nd_d = 1'b1;
              ferr_f_d  = stop_err;
            end else begin
              vld_d   = 1'b1;
              dat_d   = shift_q;
              perr_d  = perr_f_q;
              ferr_d  = stop_err;
              armed_d = 1'b0;
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx_bus.rx_dat     = dat_q;
  assign rx_bus.rx_vld     = vld_q;
  assign rx_bus.parity_err = perr_q;
  assign rx_bus.frame_err  = ferr_q;
  assign rx_bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 clocks, 64 clocks per bit, hand-built frames.
module tb_uart_rx;
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [6:0] i_config = 7'd0;
  logic       i_sample_tick = 1'b0;
  logic       i_rx = 1'b1;
  int         errors = 0;
  int         checks = 0;
  int         vld_cnt = 0;

  uart_rx_if bus ();

  uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_config      (i_config),
    .i_sample_tick (i_sample_tick),
    .i_rx          (i_rx),
    .rx_bus        (bus)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    logic [1:0] div;
    div = 2'd0;
    forever begin
      @(negedge i_clk);
      i_sample_tick = (div == 2'd3);
      div = div + 2'd1;
    end
  end

  // a valid held for two cycles counts twice, so the count also checks pulse width
  always @(posedge i_clk) if (bus.rx_vld === 1'b1) vld_cnt <= vld_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic store_cfg(input logic [6:0] c);
    @(negedge i_clk); i_config = c;
    @(negedge i_clk); i_config = 7'd0;
  endtask

  // start, data LSB first, optional parity, stop bits; optional config pulse during data bit 3
  task automatic send_frame(input logic [8:0] d, input int nbits, input bit par_en,
                            input logic par_bit, input int nstop, input logic stop_val,
                            input logic [6:0] cfg_mid);
    logic [15:0] seq;
    int n;
    seq = 16'd0;
    n = 1;
    for (int i = 0; i < nbits; i++) begin seq[n] = d[i]; n++; end
    if (par_en) begin seq[n] = par_bit; n++; end
    for (int i = 0; i < nstop; i++) begin seq[n] = stop_val; n++; end
    for (int b = 0; b < n; b++) begin
      @(negedge i_clk); i_rx = seq[b];
      if (b == 4 && cfg_mid != 7'd0) begin
        @(negedge i_clk); i_config = cfg_mid;
        chk("busy_at_cfg", 32'(bus.busy), 32'd1);
        @(negedge i_clk); i_config = 7'd0;
        repeat (61) @(negedge i_clk);
      end else begin
        repeat (63) @(negedge i_clk);
      end
    end
  endtask

  task automatic chk_out(input string tag, input int exp_cnt, input logic [8:0] dat,
                         input logic pe, input logic fe);
    repeat (4) @(negedge i_clk);
    chk({tag, "_cnt"},  32'(vld_cnt), 32'(exp_cnt));
    chk({tag, "_dat"},  32'(bus.rx_dat), 32'(dat));
    chk({tag, "_perr"}, 32'(bus.parity_err), 32'(pe));
    chk({tag, "_ferr"}, 32'(bus.frame_err), 32'(fe));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_dat",  32'(bus.rx_dat), 32'd0);
    chk("rst_vld",  32'(bus.rx_vld), 32'd0);
    chk("rst_perr", 32'(bus.parity_err), 32'd0);
    chk("rst_ferr", 32'(bus.frame_err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    i_rst = 1'b0;
    repeat (40) @(negedge i_clk);

    // default config: 8 bits, even parity, 1 stop; 0xA5 has four ones -> parity 0
    send_frame(9'h0A5, 8, 1'b1, 1'b0, 1, 1'b1, 7'd0);
    chk_out("t1", 1, 9'h0A5, 1'b0, 1'b0);

    // 0x7B: 2 stops, parity on, word 13 clamps to 9; nine ones need parity 1, send 0
    store_cfg(7'h7B);
    repeat (20) @(negedge i_clk);
    send_frame(9'h1FF, 9, 1'b1, 1'b0, 2, 1'b1, 7'd0);
    chk_out("t2", 2, 9'h1FF, 1'b1, 1'b0);

    // 0x03: word 1 clamps to 5, no parity, 1 stop; low stop bit, then a long break
    store_cfg(7'h03);
    repeat (20) @(negedge i_clk);
    send_frame(9'h01F, 5, 1'b0, 1'b0, 1, 1'b0, 7'd0);
    chk_out("t3", 3, 9'h01F, 1'b0, 1'b1);
    repeat (40 * 64) @(negedge i_clk);
    chk("break_cnt",  32'(vld_cnt), 32'd3);
    chk("break_busy", 32'(bus.busy), 32'd0);
    i_rx = 1'b1;
    repeat (128) @(negedge i_clk);
    chk("break_end_cnt", 32'(vld_cnt), 32'd3);

    // 3-tick glitch on an idle line
    i_rx = 1'b0;
    repeat (12) @(negedge i_clk);
    chk("glitch_busy_hi", 32'(bus.busy), 32'd1);
    i_rx = 1'b1;
    repeat (40) @(negedge i_clk);
    chk("glitch_busy_lo", 32'(bus.busy), 32'd0);
    chk("glitch_cnt", 32'(vld_cnt), 32'd3);

    // reset mid data bit 4 of a 5-bit frame
    i_rx = 1'b0; repeat (64) @(negedge i_clk);
    for (int i = 0; i < 4; i++) begin i_rx = 1'b1; repeat (64) @(negedge i_clk); end
    i_rx = 1'b0; repeat (32) @(negedge i_clk);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_dat",  32'(bus.rx_dat), 32'd0);
    chk("mid_rst_ferr", 32'(bus.frame_err), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_vld",  32'(bus.rx_vld), 32'd0);
    i_rx = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (128) @(negedge i_clk);
    chk("post_rst_cnt", 32'(vld_cnt), 32'd3);
    // reset restored 8 bits + parity; 0x55 has four ones -> parity 0
    send_frame(9'h055, 8, 1'b1, 1'b0, 1, 1'b1, 7'd0);
    chk_out("t5", 4, 9'h055, 1'b0, 1'b0);

    // config store during a frame is ignored; 0xC3 has four ones -> parity 0
    send_frame(9'h0C3, 8, 1'b1, 1'b0, 1, 1'b1, 7'h0B);
    chk_out("t6", 5, 9'h0C3, 1'b0, 1'b0);
    store_cfg(7'h0B);
    repeat (20) @(negedge i_clk);
    send_frame(9'h015, 5, 1'b0, 1'b0, 1, 1'b1, 7'd0);
    chk_out("t6b", 6, 9'h015, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
